intc_sched: RTL
===============

Name: intc_sched

Overview:
- Interrupt controller between the peripheral interrupt lines (timers, UART, external pins) and the CP0 HWInt inputs.
- Synchronizes six device request lines and latches them as edge- or level-triggered pending bits.
- Masks the pending bits and presents a registered HWInt vector to CP0.
- Sequences claim/EOI servicing so that only one interrupt is in service at a time. Accessed by the CPU as an MMIO device through the bridge.

Parameters:
- NSRC, 6, number of interrupt sources; fixed to the CP0 HWInt width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- irq_src  in  6  raw device interrupt requests, asynchronous to clk
- addr  in  3  word index of MMIO register (bus byte address bits [4:2])
- we  in  1  MMIO write strobe
- re  in  1  MMIO read strobe; only CLAIM reads have a side effect
- wdata  in  32  MMIO write data
- rdata  out  32  MMIO read data, combinational from addr
- hwint  out  6  registered interrupt vector to CP0 HWInt

Behaviour:
- Registers (addr):
  - 0 PEND: reads pend[5:0]. A write is W1C on edge-mode bits only; level-mode bits ignore it.
  - 1 ENABLE: RW [5:0].
  - 2 MODE: RW [5:0]; 1 = rising-edge, 0 = level.
  - 3 CLAIM: RO; returns {valid[31], 28'b0, id[2:0]}.
  - 4 EOI: WO; wdata[2:0] = id.
  - 5 STATUS: RO; {err[8], state[5:4], isr_id[2:0]}.
  - 6–7: read 0, writes ignored.
- Synchronizer: two flops s1, s2, plus s3 for edge detect.
- Pending update:
  - Level bits: pend <= s2.
  - Edge bits: set when s2 & ~s3. Cleared by claim of that id or by PEND W1C. If set and clear occur in the same cycle, set wins.
- Latency: irq_src high before edge k → s2 after k+1 → pend after k+2 → hwint after k+3.
- act = pend & ENABLE. sel = lowest set index of act (priority: index 0 highest).
- FSM, state encoding IDLE=0, ASSERT=1, SERVICE=2:
  - IDLE: hwint = 0. If |act, go to ASSERT.
  - ASSERT: hwint <= act, updated every cycle.
    - A CLAIM read (re, addr=3) returns valid=1 with id=sel. It latches isr_id=sel, clears edge pend[sel] and sets hwint <= 0, all at that edge. Go to SERVICE.
    - If act becomes 0 (level line released, disabled, or W1C), go to IDLE and hwint <= 0.
  - SERVICE: hwint held at 0; no nesting.
    - An EOI write with wdata[2:0]==isr_id goes to IDLE. The next cycle re-evaluates act.
    - An EOI with a mismatched id is ignored and sets sticky err. err is cleared by any write to STATUS.
- CLAIM read outside ASSERT returns 0 with no side effect. EOI outside SERVICE sets err.
- Simultaneous MMIO write and CLAIM read in the same cycle are not possible (single bus master); no ordering rule is needed.
- Level source still high after EOI: pend remains set, so the FSM re-enters ASSERT one cycle after IDLE.
- Reset: s1/s2/s3, pend, ENABLE, MODE, isr_id and err = 0; state = IDLE; hwint = 0; rdata = 0 for every addr.
- Reset mid-service drops every pending and in-service interrupt. Edges seen during reset are lost.

Optional Feature:
- Macro: INTC_IRQ_COUNT_EN.
- When defined:
  - Six 16-bit counters, one per source, increment on each successful claim of that id and saturate at 0xFFFF.
  - Readable at addr 6 (sources 0–1 packed {cnt1,cnt0}) and addr 7 (indexed by ENABLE-independent wdata-free rotating select: read of addr 7 returns {cnt[sel_r+1], cnt[sel_r]}; sel_r advances by 2 on each addr 7 read, wrapping 2→4→2).
  - Any write to addr 6 clears all counters.
  - Counters reset to 0.
- When not defined: addr 6/7 read 0, and no counter logic is built.

Test Plan:
- Reset, then read all registers → all 0; hwint=0; STATUS state=0.
- ENABLE=0x04, MODE=0; hold irq_src[2]=1 from edge 10 → hwint=0x04 after edge 13. CLAIM → 0x80000002, hwint=0. EOI id 2 with line still high → hwint=0x04 again two cycles later.
- MODE=0x3F, ENABLE=0x3F; pulse irq_src[5] and irq_src[1] for one cycle each → PEND=0x22. CLAIM id 1 → PEND=0x20. EOI 1 → CLAIM returns 0x80000005.
- In SERVICE with isr_id=3, EOI id 4 → state stays 2 and STATUS err=1. EOI id 3 → IDLE. Write STATUS → err=0.
- In ASSERT with level source 0 only, clear ENABLE → IDLE and hwint=0 next edge. A CLAIM read then returns 0.
- Assert reset while in SERVICE with edge pend=0x11 → next cycle state=IDLE, PEND=0, hwint=0. With INTC_IRQ_COUNT_EN, 3 claims of id 0 → addr 6 low half = 3.

Source files
------------

// File: rtl/intc_sched.sv
// intc_sched: six-source interrupt controller in front of CP0 HWInt, with claim/EOI sequencing.
// Define INTC_IRQ_COUNT_EN to build per-source saturating claim counters, readable at addr 6/7.
module intc_sched #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [2:0]      addr,
  input  logic            we,
  input  logic            re,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] hwint
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [2:0] ADDR_PEND   = 3'd0;
  localparam logic [2:0] ADDR_ENABLE = 3'd1;
  localparam logic [2:0] ADDR_MODE   = 3'd2;
  localparam logic [2:0] ADDR_CLAIM  = 3'd3;
  localparam logic [2:0] ADDR_EOI    = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic [NSRC-1:0] s1_reg, s2_reg, s3_reg;
  logic [NSRC-1:0] pend_reg, pend_next;
  logic [NSRC-1:0] enable_reg, mode_reg;
  logic [NSRC-1:0] hwint_reg, hwint_next;
  logic [1:0]      state_reg, state_next;
  logic [2:0]      isr_id_reg, isr_id_next;
  logic            err_reg, err_next;

  logic [NSRC-1:0] act;
  logic [NSRC-1:0] edge_set;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] claim_clr;
  logic [NSRC-1:0] w1c;
  logic [2:0]      sel;
  logic            claim_fire;
  logic            eoi_wr;
  logic            unused_wdata;

  assign unused_wdata = ^wdata[31:NSRC];

  assign act        = pend_reg & enable_reg;
  assign edge_set   = s2_reg & ~s3_reg;
  assign claim_fire = re && (addr == ADDR_CLAIM) && (state_reg == ST_ASSERT) && (|act);
  assign eoi_wr     = we && (addr == ADDR_EOI);
  assign w1c        = (we && (addr == ADDR_PEND)) ? wdata[NSRC-1:0] : '0;
  assign claim_clr  = claim_fire ? (NSRC'(1) << sel) : '0;
  assign pend_clr   = w1c | claim_clr;
  assign hwint      = hwint_reg;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) sel = 3'(i);
    end
  end

  // Edge bits: a new rising edge beats any same-cycle clear. Level bits just follow the line.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
    assign pend_next[gi] = mode_reg[gi] ? (edge_set[gi] | (pend_reg[gi] & ~pend_clr[gi]))
                                        : s2_reg[gi];
  end

  always_comb begin
    state_next  = state_reg;
    hwint_next  = '0;
    isr_id_next = isr_id_reg;
    err_next    = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|act) begin
          state_next = ST_ASSERT;
          hwint_next = act;
        end
      end
      ST_ASSERT: begin
        if (claim_fire) begin
          isr_id_next = sel;
          state_next  = ST_SERVICE;
        end else if (!(|act)) begin
          state_next = ST_IDLE;
        end else begin
          hwint_next = act;
        end
      end
      ST_SERVICE: begin
        if (eoi_wr && (wdata[2:0] == isr_id_reg)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (eoi_wr && !((state_reg == ST_SERVICE) && (wdata[2:0] == isr_id_reg))) err_next = 1'b1;
    if (we && (addr == ADDR_STATUS)) err_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg     <= '0;
      s2_reg     <= '0;
      s3_reg     <= '0;
      pend_reg   <= '0;
      enable_reg <= '0;
      mode_reg   <= '0;
      hwint_reg  <= '0;
      state_reg  <= ST_IDLE;
      isr_id_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      s1_reg     <= irq_src;
      s2_reg     <= s1_reg;
      s3_reg     <= s2_reg;
      pend_reg   <= pend_next;
      if (we && (addr == ADDR_ENABLE)) enable_reg <= wdata[NSRC-1:0];
      if (we && (addr == ADDR_MODE))   mode_reg   <= wdata[NSRC-1:0];
      hwint_reg  <= hwint_next;
      state_reg  <= state_next;
      isr_id_reg <= isr_id_next;
      err_reg    <= err_next;
    end
  end

`ifdef INTC_IRQ_COUNT_EN
  logic [15:0]     cnt_reg [NSRC];
  logic [NSRC-1:0] cnt_inc;
  logic [2:0]      sel_r_reg;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_cnt_inc
    assign cnt_inc[gi] = claim_fire && (sel == 3'(gi)) && (cnt_reg[gi] != 16'hFFFF);
  end

  always_ff @(posedge clk) begin
    if (reset || (we && (addr == 3'd6))) begin
      for (int i = 0; i < NSRC; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (cnt_inc[i]) cnt_reg[i] <= cnt_reg[i] + 16'd1;
      end
    end
  end

  // Addr 7 alternates between the {3,2} and {5,4} counter pairs on every read.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_r_reg <= 3'd2;
    end else if (re && (addr == 3'd7)) begin
      sel_r_reg <= (sel_r_reg == 3'd4) ? 3'd2 : 3'd4;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_PEND:   rdata[NSRC-1:0] = pend_reg;
      ADDR_ENABLE: rdata[NSRC-1:0] = enable_reg;
      ADDR_MODE:   rdata[NSRC-1:0] = mode_reg;
      ADDR_CLAIM: begin
        if ((state_reg == ST_ASSERT) && (|act)) rdata = {1'b1, 28'd0, sel};
      end
      ADDR_STATUS: rdata = {23'd0, err_reg, 2'd0, state_reg, 1'b0, isr_id_reg};
`ifdef INTC_IRQ_COUNT_EN
      3'd6: rdata = {cnt_reg[1], cnt_reg[0]};
      3'd7: rdata = {cnt_reg[sel_r_reg + 3'd1], cnt_reg[sel_r_reg]};
`endif
      default: rdata = '0;
    endcase
  end

endmodule
